pipe_hazard_unit: RTL
=====================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning number of ID-stage source operands checked.
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, range 1..7, meaning load-use bubble cycles.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 The block SHALL have ports `clk  in  1  clock, rising edge`.
REQ-006 The block SHALL have port `rst_n  in  1  reset`; one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port `id_mem_read  in  1  instruction in EX (latched from ID) is a load`.
REQ-008 The block SHALL have port `id_rd_addr  in  REG_AW  destination of that load`.
REQ-009 The block SHALL have ports `rs_addr  in  NUM_SRC*REG_AW  packed ID sources, src i at [i*REG_AW +: REG_AW]` and `rs_used  in  NUM_SRC  per-source valid mask`.
REQ-010 The block SHALL have port `branch_ctrl  in  2  00 none, 01 B, 10 JALR, 11 J`.
REQ-011 The block SHALL have port `mem_busy  in  1  instruction or data memory not ready this cycle`.
REQ-012 The block SHALL have port `cnt_clr  in  1  synchronous clear of stall_cnt`.
REQ-013 The block SHALL have outputs `pc_write`, `ifid_write`, `instr_flush`, `ctrl_flush`, `pipe_hold`, each 1 bit, meaning PC enable, IF/ID enable, IF/ID flush, ID/EX control bubble, and freeze of ID/EX, EX/MEM and MEM/WB.
REQ-014 The block SHALL have output `stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0`.

Function
REQ-015 FSM states SHALL be S_RUN, S_LU (load-use bubbles pending) and S_MEM (memory freeze); a down-counter lu_cnt of 3 bits and a resume register (state, lu_cnt) SHALL exist.
REQ-016 Hazard hit SHALL be: id_mem_read=1, id_rd_addr!=0, and for some i rs_used[i]=1 with rs_addr[i]==id_rd_addr.
REQ-017 Priority SHALL be mem_busy > branch_ctrl!=00 > load-use (hit or S_LU).
REQ-018 When mem_busy=1, outputs SHALL be pc_write=0, ifid_write=0, instr_flush=0, ctrl_flush=0, pipe_hold=1, combinationally in the same cycle; next state is S_MEM and the resume register captures the current state/lu_cnt on entry only.
REQ-019 In S_MEM with mem_busy=0, the block SHALL restore the resume state and lu_cnt, evaluating outputs for that cycle as in the restored state; lu_cnt SHALL NOT decrement while frozen.
REQ-020 With mem_busy=0 and branch_ctrl!=00, outputs SHALL be pc_write=1, ifid_write=1, instr_flush=1, ctrl_flush=1, pipe_hold=0; next state is S_RUN and any pending load-use bubbles are discarded.
REQ-021 With a hit in S_RUN, outputs SHALL be pc_write=0, ifid_write=0, instr_flush=0, ctrl_flush=1 in the detecting cycle; if LOAD_LAT>1, next state is S_LU with lu_cnt=LOAD_LAT-1.
REQ-022 In S_LU, the block SHALL drive the same stall outputs as REQ-021 and decrement lu_cnt; it SHALL return to S_RUN when lu_cnt reaches 1 at the clock edge, so there are exactly LOAD_LAT bubble cycles total, with a new hit not re-armed during S_LU.
REQ-023 Otherwise, outputs SHALL be pc_write=1, ifid_write=1, instr_flush=0, ctrl_flush=0, pipe_hold=0.
REQ-024 stall_cnt SHALL increment on every clock where pc_write=0, saturate at all-ones, and clear to 0 on cnt_clr=1, with clear winning over increment.
REQ-025 With LOAD_LAT=1 and mem_busy=0, outputs SHALL be cycle-identical to a purely combinational single-bubble load-use/branch hazard unit.

Reset
REQ-026 When rst_n=0, the block SHALL asynchronously set state=S_RUN, lu_cnt=0, resume register=S_RUN/0, and stall_cnt=0.
REQ-027 During and after reset, outputs SHALL follow REQ-018..REQ-023 from S_RUN; reset asserted mid S_LU or S_MEM SHALL abandon all pending bubbles.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the branch_ctrl encoding constants (BR_NONE, BR_B, BR_JALR, BR_J) and the state enum typedef.
REQ-029 One sub-module, hazard_match, SHALL implement the parametrised NUM_SRC comparator of REQ-016 (purely combinational); all sequential logic SHALL live in pipe_hazard_unit.

Verification
REQ-030 Test: LOAD_LAT=1, load rd=5, rs_addr={5,3}, rs_used=2'b11 -> one cycle pc_write=0, ctrl_flush=1; stall_cnt=1.
REQ-031 Test: LOAD_LAT=3, same hit -> exactly 3 consecutive bubble cycles then normal; stall_cnt=3; rd=0 with rs=0 -> no stall.
REQ-032 Test: LOAD_LAT=3, mem_busy high for 4 cycles starting at bubble 2 -> pipe_hold=1 for 4 cycles, then bubbles 2,3 resume; total pc_write=0 cycles=7.
REQ-033 Test: branch_ctrl=10 during S_LU bubble 2 -> instr_flush=1, ctrl_flush=1, pc_write=1 that cycle; no further bubbles.
REQ-034 Test: rs_used=2'b01 with rs_addr[1]==rd -> no stall; branch_ctrl=01 together with mem_busy=1 -> freeze only, flush occurs in the first cycle mem_busy=0.
REQ-035 Test: CNT_W=4, 20 stall cycles -> stall_cnt=15; cnt_clr=1 -> 0; rst_n low mid S_MEM -> S_RUN, normal outputs once mem_busy=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard logic.
package pipe_pkg;

    // Branch/jump class of the instruction resolved in EX.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_B    = 2'b01;
    localparam logic [1:0] BR_JALR = 2'b10;
    localparam logic [1:0] BR_J    = 2'b11;

    // Hazard FSM: normal flow, load-use bubbles pending, memory freeze.
    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_LU  = 2'd1,
        S_MEM = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Load-use source comparator: flags a hit when any live ID source reads the
// register that the load in EX is about to write (x0 never hazards).
module hazard_match #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
) (
    input  logic                      memRead,
    input  logic [REG_AW-1:0]         rdAddr,
    input  logic [NUM_SRC*REG_AW-1:0] rsAddr,
    input  logic [NUM_SRC-1:0]        rsUsed,
    output logic                      hit
);

    logic [NUM_SRC-1:0] srcMatch;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        assign srcMatch[i] = rsUsed[i] && (rsAddr[i*REG_AW +: REG_AW] == rdAddr);
    end

    assign hit = memRead && (rdAddr != '0) && (|srcMatch);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard control: memory freeze, branch flush and multi-cycle
// load-use bubbles, plus a saturating stall-cycle counter.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_mem_read,
    input  logic [REG_AW-1:0]         id_rd_addr,
    input  logic [NUM_SRC*REG_AW-1:0] rs_addr,
    input  logic [NUM_SRC-1:0]        rs_used,
    input  logic [1:0]                branch_ctrl,
    input  logic                      mem_busy,
    input  logic                      cnt_clr,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      instr_flush,
    output logic                      ctrl_flush,
    output logic                      pipe_hold,
    output logic [CNT_W-1:0]          stall_cnt
);

    // Bubbles still owed after the detecting cycle.
    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    logic       hit;
    state_t     state, stateNext, resState, resStateNext, effState;
    logic [2:0] luCnt, luCntNext, resCnt, resCntNext, effCnt;

    hazard_match #(
        .REG_AW (REG_AW),
        .NUM_SRC(NUM_SRC)
    ) uMatch (
        .memRead(id_mem_read),
        .rdAddr (id_rd_addr),
        .rsAddr (rs_addr),
        .rsUsed (rs_used),
        .hit    (hit)
    );

    // State, bubble counter and the context saved across a memory freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            luCnt    <= 3'd0;
            resState <= S_RUN;
            resCnt   <= 3'd0;
        end else begin
            state    <= stateNext;
            luCnt    <= luCntNext;
            resState <= resStateNext;
            resCnt   <= resCntNext;
        end
    end

    // Next state and pipeline controls; leaving a freeze behaves as the saved state.
    always_comb begin
        stateNext    = state;
        luCntNext    = luCnt;
        resStateNext = resState;
        resCntNext   = resCnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        instr_flush  = 1'b0;
        ctrl_flush   = 1'b0;
        pipe_hold    = 1'b0;
        effState     = state;
        effCnt       = luCnt;
        if (state == S_MEM) begin
            effState = resState;
            effCnt   = resCnt;
        end

        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            stateNext  = S_MEM;
            // Capture context only on entry so a long freeze keeps the original.
            if (state != S_MEM) begin
                resStateNext = state;
                resCntNext   = luCnt;
            end
        end else if (branch_ctrl != BR_NONE) begin
            instr_flush = 1'b1;
            ctrl_flush  = 1'b1;
            stateNext   = S_RUN;
            luCntNext   = 3'd0;
        end else if (effState == S_LU) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_flush = 1'b1;
            if (effCnt <= 3'd1) begin
                stateNext = S_RUN;
                luCntNext = 3'd0;
            end else begin
                stateNext = S_LU;
                luCntNext = effCnt - 3'd1;
            end
        end else if (hit) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_flush = 1'b1;
            if (LOAD_LAT > 1) begin
                stateNext = S_LU;
                luCntNext = LU_INIT;
            end else begin
                stateNext = S_RUN;
                luCntNext = 3'd0;
            end
        end else begin
            stateNext = S_RUN;
            luCntNext = 3'd0;
        end
    end

    // Count stalled fetch cycles, saturating; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
